// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a shared 4:1 mux.
// The previous owner is always lowest priority, and a hold limit stops any one requester from keeping the mux forever.
module mux_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic [1:0] owner,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } pick_t;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Scan from last+4 (last itself) down to last+1, so the nearest index after last wins.
  function automatic pick_t rr_pick(input logic [3:0] r, input logic [1:0] last);
    pick_t      res;
    logic [1:0] idx;
    res = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) begin
        res.valid = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  logic [3:0] owner_oh;
  logic       rel_done;
  logic       rel_drop;
  logic       rel_hold;
  logic       release_now;
  pick_t      winner;

  assign owner_oh    = onehot(owner_q);
  assign rel_done    = done[owner_q];
  assign rel_drop    = ~req[owner_q];
  assign rel_hold    = (cnt_q == HOLD_LIM) && ((req & ~owner_oh) != 4'b0000);
  assign release_now = rel_done || rel_drop || rel_hold;
  // Whenever a hold-limit release fires, some other request is pending and outranks the owner.
  assign winner      = rr_pick(req, owner_q);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (winner.valid) begin
          state_d = GRANT;
          gnt_d   = onehot(winner.idx);
          owner_d = winner.idx;
          cnt_d   = CNT_ONE;
        end
      end
      GRANT: begin
        if (release_now) begin
          if (winner.valid) begin
            gnt_d   = onehot(winner.idx);
            owner_d = winner.idx;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            cnt_d   = '0;
          end
        end else if (cnt_q < HOLD_LIM) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: state updates use <= so every register samples the pre-edge values together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      owner_q <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign s1    = owner_q[1];
  assign s0    = owner_q[0];
  assign busy  = |gnt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: reset, rotation, hold limit, preemption, ignored done and mid-grant reset.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic       s1;
  logic       s0;
  logic [1:0] owner;
  logic       busy;

  int checks;
  int errors;

  mux_rr_arbiter #(.HOLD_MAX(4), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .done  (done),
    .gnt   (gnt),
    .s1    (s1),
    .s0    (s0),
    .owner (owner),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed bundle {gnt, owner, busy, s1, s0}.
  function automatic logic [8:0] observed();
    return {gnt, owner, busy, s1, s0};
  endfunction

  function automatic logic [8:0] expect_vec(input logic [3:0] g, input logic [1:0] o);
    return {g, o, (g != 4'b0000), o[1], o[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    do_reset();
    exp = expect_vec(4'b0000, 2'd3);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL reset: got %b want %b", observed(), exp);
    end
  endtask

  task automatic test_single();
    logic [8:0] exp;
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp = expect_vec(4'b0001, 2'd0);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL single_grant[%0d]: got %b want %b", i, observed(), exp);
      end
    end
    req = 4'b0000;
    tick();
    exp = expect_vec(4'b0000, 2'd0);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL single_release: got %b want %b", observed(), exp);
    end
  endtask

  task automatic test_rotate();
    logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [8:0] exp;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp = expect_vec(4'b0001 << order[i], order[i]);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL rotate[%0d]: got %b want %b", i, observed(), exp);
      end
      done = 4'b0001 << order[i];
    end
    done = 4'b0000;
  endtask

  task automatic test_hold_limit();
    logic [1:0] seq [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1,
                             2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [8:0] exp;
    do_reset();
    req = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp = expect_vec(4'b0001 << seq[i], seq[i]);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL hold_limit[%0d]: got %b want %b", i, observed(), exp);
      end
    end
  endtask

  task automatic test_no_starve();
    logic [8:0] exp;
    do_reset();
    req = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp = expect_vec(4'b0100, 2'd2);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL solo_hold[%0d]: got %b want %b", i, observed(), exp);
      end
    end
    req = 4'b0101;
    tick();
    exp = expect_vec(4'b0001, 2'd0);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL preempt: got %b want %b", observed(), exp);
    end
  endtask

  task automatic test_nonowner_done();
    logic [8:0] exp;
    do_reset();
    req = 4'b0010;
    tick();
    req  = 4'b1010;
    done = 4'b1000;
    tick();
    exp = expect_vec(4'b0010, 2'd1);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL nonowner_done: got %b want %b", observed(), exp);
    end
    done = 4'b0010;
    tick();
    done = 4'b0000;
    exp = expect_vec(4'b1000, 2'd3);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL owner_done: got %b want %b", observed(), exp);
    end
  endtask

  task automatic test_idle_done();
    logic [8:0] exp;
    do_reset();
    done = 4'b1111;
    tick();
    done = 4'b0000;
    req  = 4'b1000;
    tick();
    exp = expect_vec(4'b1000, 2'd3);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL idle_done: got %b want %b", observed(), exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] exp;
    do_reset();
    req = 4'b0100;
    tick();
    req   = 4'b1111;
    rst_n = 1'b0;
    tick();
    exp = expect_vec(4'b0000, 2'd3);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL reset_mid: got %b want %b", observed(), exp);
    end
    rst_n = 1'b1;
    tick();
    exp = expect_vec(4'b0001, 2'd0);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL reset_mid_regrant: got %b want %b", observed(), exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    req    = 4'b0000;
    done   = 4'b0000;
    test_reset();
    test_single();
    test_rotate();
    test_hold_limit();
    test_no_starve();
    test_nonowner_done();
    test_idle_done();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one mux_4x1 datapath among four requesters.
- Grants one requester at a time and drives the mux select lines (s1, s0) so the mux output presents the granted requester's input.
- Enforces a maximum hold time so that no requester can starve the others.
- Sits between the requester blocks and the mux_4x1 select inputs.

Parameters:
- HOLD_MAX, 4: maximum consecutive grant cycles before the owner is preempted, when another request is pending; legal range 1..7.
- CNT_W, 3: width of the hold counter; must hold HOLD_MAX.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- req  input  4  request vector; bit i = requester i wants the mux.
- done  input  4  release strobe; bit i = requester i finished. Ignored unless i is the current owner.
- gnt  output  4  one-hot grant, registered; all-zero when idle.
- s1  output  1  mux select MSB (owner[1]).
- s0  output  1  mux select LSB (owner[0]).
- owner  output  2  index of the current or most recent owner.
- busy  output  1  high while any grant is active.

Behaviour:
- Clocking and reset:
  - Single clock; reset is synchronous and active-low.
  - Reset has priority over every other input in the same cycle.
- Reset values:
  - gnt=4'b0000, busy=0, owner=2'd3, s1=1, s0=1.
  - Hold counter = 0; state = IDLE.
  - owner=3 at reset makes requester 0 highest priority on the first arbitration.
- Invariants:
  - s1/s0 always equal owner[1]/owner[0].
  - busy == |gnt.
  - gnt is always one-hot or zero.
- States: IDLE, GRANT.
- Arbitration function:
  - Search req starting at index (owner+1) mod 4, wrapping; the first set bit wins.
  - The previous owner is therefore lowest priority.
- IDLE:
  - If req != 0: on the next edge go to GRANT, gnt = onehot(winner), owner = winner, counter = 1.
  - Latency from req to gnt is exactly 1 cycle.
  - If req == 0: stay in IDLE; owner, s1 and s0 hold their values.
- GRANT, release conditions (evaluated each cycle):
  - (a) done[owner]=1;
  - (b) req[owner]=0;
  - (c) counter == HOLD_MAX and (req & ~onehot(owner)) != 0.
- GRANT, no release:
  - Keep the grant.
  - Counter increments and saturates at HOLD_MAX.
  - If the counter is at HOLD_MAX and no other requester is pending, the owner keeps the grant indefinitely.
- GRANT, release:
  - Arbitrate on req in the same cycle.
  - For (a), the owner's req bit still counts but is lowest priority.
  - For (c), the owner can never win.
  - If a winner exists: switch gnt/owner directly on the next edge (back-to-back, no idle cycle), counter = 1.
  - If no winner: go to IDLE, gnt = 0, busy = 0, owner/s1/s0 retain the last owner.
- done bits for non-owners are ignored in all states; done is ignored in IDLE.
- Simultaneous release and new request: handled by the same-cycle re-arbitration above.
- Reset mid-grant: the next edge with rst_n=0 forces all reset values, regardless of req/done.

Test Plan:
- Reset, then req=4'b0001 held for 2 cycles, then dropped:
  - gnt=0001, owner=0, s1s0=00 one cycle after req rises;
  - gnt=0000, busy=0 one cycle after req drops; s1s0 stays 00.
- Starting from reset, req=4'b1111 held, done pulsed on the owner each cycle after it is granted:
  - grant order 0,1,2,3,0;
  - s1s0 sequence 00,01,10,11,00;
  - no idle cycle between grants.
- HOLD_MAX=4, req=4'b0011 held, done never asserted:
  - owner 0 holds gnt for exactly 4 cycles, then gnt=0010 for 4 cycles, then back to 0001.
- req=4'b0100 alone held for 10 cycles, no done:
  - gnt=0100 stays continuously (no preemption without competition);
  - at cycle 6 raise req[0]: gnt moves to 0001 on the next edge.
- Owner=1 granted; pulse done=4'b1000 (non-owner) while req=4'b1010:
  - grant unchanged; then done=4'b0010 → gnt=1000, s1s0=11 next edge.
- Mid-grant (gnt=0100), assert rst_n=0 for 1 cycle while req=1111:
  - next edge gnt=0000, owner=3, busy=0;
  - after release, first grant goes to requester 0.
